pipe_stage_skid: RTL

//  Parametrised inter-stage pipeline register (EX->MEM and later stages) with valid/ready handshake.
//  Two-entry skid buffer registers s_ready, which breaks the combinational ready path back to EX.

---
 rtl/pipe_pkg.sv | 20 ++
 rtl/pipe_perf_cnt.sv | 26 ++
 rtl/pipe_stage_skid.sv | 135 +++++++++++++
 3 files changed

// File: rtl/pipe_pkg.sv
// Shared types and constants for the inter-stage pipeline register.
// The perf counters are built only when PIPE_STAGE_PERF_EN is defined.
package pipe_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } pipe_state_e;

  localparam int CTRL_REG_WRITE  = 0;
  localparam int CTRL_REG_SRC_LO = 1;
  localparam int CTRL_REG_SRC_HI = 2;
  localparam int CTRL_MEM_READ   = 3;
  localparam int CTRL_MEM_WRITE  = 4;

  // Squash drops only the load side effect unless a stage overrides it.
  localparam logic [5:0] SQUASH_MASK_DEFAULT = 6'(1 << CTRL_MEM_READ);

endpackage

// File: rtl/pipe_perf_cnt.sv
// 32-bit saturating event counter, present only when PIPE_STAGE_PERF_EN is defined.
`ifdef PIPE_STAGE_PERF_EN
module pipe_perf_cnt (
  input  logic        clk,
  input  logic        rst,
  input  logic        en_i,
  output logic [31:0] cnt_o
);

  logic [31:0] cnt_q;
  logic [31:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (en_i && (cnt_q != 32'hFFFF_FFFF)) cnt_d = cnt_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;

endmodule
`endif

// File: rtl/pipe_stage_skid.sv
// Two-entry skid pipeline register with flush and in-place squash of the head entry.
// Defining PIPE_STAGE_PERF_EN adds saturating stall/bubble counters.
module pipe_stage_skid
  import pipe_pkg::*;
#(
  parameter int                DATA_W      = 64,
  parameter int                CTRL_W      = 6,
  parameter logic [CTRL_W-1:0] SQUASH_MASK = CTRL_W'(SQUASH_MASK_DEFAULT)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [CTRL_W-1:0] s_ctrl,
  input  logic [DATA_W-1:0] s_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [CTRL_W-1:0] m_ctrl,
  output logic [DATA_W-1:0] m_data,
  input  logic              flush,
  input  logic              squash,
`ifdef PIPE_STAGE_PERF_EN
  output logic [31:0]       perf_stall_cnt,
  output logic [31:0]       perf_bubble_cnt,
`endif
  output pipe_state_e       dbg_state_o
);

  // Handshake: a beat moves when valid & ready are both high at a rising edge;
  // valid never waits on ready, and the offered beat is stable until taken.

  pipe_state_e       state_q, state_d;
  logic              s_ready_q;
  logic [CTRL_W-1:0] head_ctrl_q, skid_ctrl_q;
  logic [DATA_W-1:0] head_data_q, skid_data_q;
  logic              xfer_in, xfer_out;
  logic              head_from_s, head_from_skid, skid_from_s;

  assign xfer_in  = s_valid & s_ready_q;
  assign xfer_out = m_valid & m_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= EMPTY;
      s_ready_q <= 1'b1;
    end else begin
      state_q   <= state_d;
      s_ready_q <= (state_d != TWO);
    end
  end

  always_comb begin
    state_d        = state_q;
    head_from_s    = 1'b0;
    head_from_skid = 1'b0;
    skid_from_s    = 1'b0;
    if (flush) begin
      state_d = EMPTY;
    end else begin
      case (state_q)
        EMPTY: if (xfer_in) begin
          state_d     = ONE;
          head_from_s = 1'b1;
        end
        ONE: begin
          if (xfer_in && xfer_out) begin
            head_from_s = 1'b1;
          end else if (xfer_in) begin
            state_d     = TWO;
            skid_from_s = 1'b1;
          end else if (xfer_out) begin
            state_d = EMPTY;
          end
        end
        TWO: if (xfer_out) begin
          state_d        = ONE;
          head_from_skid = 1'b1;
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  always_comb begin
    m_valid     = (state_q != EMPTY);
    s_ready     = s_ready_q;
    m_ctrl      = head_ctrl_q;
    m_data      = head_data_q;
    dbg_state_o = state_q;
  end

  // A head that leaves this cycle is replaced, so a concurrent squash has nothing to act on.
  always_ff @(posedge clk) begin
    if (rst) begin
      head_ctrl_q <= '0;
      head_data_q <= '0;
      skid_ctrl_q <= '0;
      skid_data_q <= '0;
    end else if (flush) begin
      head_ctrl_q <= '0;
      skid_ctrl_q <= '0;
    end else begin
      if (head_from_s) begin
        head_ctrl_q <= s_ctrl;
        head_data_q <= s_data;
      end else if (head_from_skid) begin
        head_ctrl_q <= skid_ctrl_q;
        head_data_q <= skid_data_q;
      end else if (squash && m_valid && !xfer_out) begin
        head_ctrl_q <= head_ctrl_q & ~SQUASH_MASK;
      end
      if (skid_from_s) begin
        skid_ctrl_q <= s_ctrl;
        skid_data_q <= s_data;
      end
    end
  end

`ifdef PIPE_STAGE_PERF_EN
  pipe_perf_cnt u_stall_cnt (
    .clk   (clk),
    .rst   (rst),
    .en_i  (m_valid & ~m_ready),
    .cnt_o (perf_stall_cnt)
  );

  pipe_perf_cnt u_bubble_cnt (
    .clk   (clk),
    .rst   (rst),
    .en_i  (~m_valid & ~rst),
    .cnt_o (perf_bubble_cnt)
  );
`endif

endmodule
